// File: rtl/clock_pkg.sv
// Shared constants and types for the wall-clock time counter.
package clock_pkg;

  // Largest value each two-digit field reaches before wrapping to 00
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  // One BCD digit as it leaves the counter towards a 7-segment decoder
  typedef logic [3:0] bcd_digit_t;

endpackage : clock_pkg

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX to 00.
// carry_out flags the wrapping increment so the next field can advance on the same edge.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t ones,
  output bcd_digit_t tens,
  output logic       carry_out
);

  localparam bcd_digit_t ONES_MAX = bcd_digit_t'(MAX % 10);
  localparam bcd_digit_t TENS_MAX = bcd_digit_t'(MAX / 10);
  localparam bcd_digit_t DIGIT_9  = bcd_digit_t'(9);

  logic at_max_c;

  // Terminal value detection drives both the wrap and the carry to the next field
  assign at_max_c  = (tens == TENS_MAX) && (ones == ONES_MAX);
  assign carry_out = inc && at_max_c;

  // Digit registers: reset beats clear, clear beats increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones <= '0;
      tens <= '0;
    end else if (clr) begin
      ones <= '0;
      tens <= '0;
    end else if (inc) begin
      if (at_max_c) begin
        ones <= '0;
        tens <= '0;
      end else if (ones == DIGIT_9) begin
        ones <= '0;
        tens <= tens + bcd_digit_t'(1);
      end else begin
        ones <= ones + bcd_digit_t'(1);
      end
    end
  end

endmodule : bcd_mod_counter

// File: rtl/clock_time_counter.sv
// 24-hour HH:MM:SS counter with a 1 Hz prescaler and a manual time-set mode.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  output bcd_digit_t sec_ones,
  output bcd_digit_t sec_tens,
  output bcd_digit_t min_ones,
  output bcd_digit_t min_tens,
  output bcd_digit_t hr_ones,
  output bcd_digit_t hr_tens,
  output logic       tick_1hz
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          wrap_c;
  logic          sec_carry_c;
  logic          min_carry_c;
  logic          min_inc_c;
  logic          hr_inc_c;
  logic          unused_hr_carry_c;

  // Prescaler terminal count only matters while actually running
  assign wrap_c = en && !set_mode && (presc == PRESC_LAST);

  // Set mode redirects minute/hour increments to the manual pulses and cuts the carry chain
  assign min_inc_c = set_mode ? inc_min : sec_carry_c;
  assign hr_inc_c  = set_mode ? inc_hr  : min_carry_c;

  // Prescaler: parked at 0 in set mode so the first tick after leaving it is a full second
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (set_mode) begin
      presc <= '0;
    end else if (en) begin
      presc <= wrap_c ? '0 : presc + PW'(1);
    end
  end

  // One-second pulse, registered alongside the seconds advance it marks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= wrap_c;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (set_mode),
    .inc       (wrap_c),
    .ones      (sec_ones),
    .tens      (sec_tens),
    .carry_out (sec_carry_c)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .inc       (min_inc_c),
    .ones      (min_ones),
    .tens      (min_tens),
    .carry_out (min_carry_c)
  );

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .inc       (hr_inc_c),
    .ones      (hr_ones),
    .tens      (hr_tens),
    .carry_out (unused_hr_carry_c)
  );

endmodule : clock_time_counter

// File: tb/tb_clock_time_counter.sv
// Scoreboard bench for clock_time_counter with a behavioural seconds-of-day model.
module tb_clock_time_counter;

  localparam int unsigned CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic       tick_1hz;

  always #5 clk = ~clk;

  clock_time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .set_mode (set_mode),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .hr_ones  (hr_ones),
    .hr_tens  (hr_tens),
    .tick_1hz (tick_1hz)
  );

  typedef struct packed {
    logic        tick;
    logic [23:0] t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_presc  = 0;
  int   m_h      = 0;
  int   m_m      = 0;
  int   m_s      = 0;
  int   ticks_seen;
  logic [7:0] tick_vec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [23:0] bcd_time(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] dut_time();
    return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Drive one cycle, predict its result, then compare after the edge
  task automatic step(input logic r, input logic e, input logic sm, input logic im, input logic ih);
    exp_t x;
    logic t;
    rst_n = r; en = e; set_mode = sm; inc_min = im; inc_hr = ih;
    t = 1'b0;
    if (!r) begin
      m_presc = 0; m_h = 0; m_m = 0; m_s = 0;
    end else if (sm) begin
      m_presc = 0; m_s = 0;
      m_m = (m_m + (im ? 1 : 0)) % 60;
      m_h = (m_h + (ih ? 1 : 0)) % 24;
    end else if (e) begin
      if (m_presc == CLK_HZ - 1) begin
        m_presc = 0;
        t = 1'b1;
        m_s++;
        if (m_s == 60) begin
          m_s = 0;
          m_m++;
          if (m_m == 60) begin
            m_m = 0;
            m_h = (m_h + 1) % 24;
          end
        end
      end else begin
        m_presc++;
      end
    end
    x.tick = t;
    x.t    = bcd_time(m_h, m_m, m_s);
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("tick", 32'(tick_1hz), 32'(x.tick));
      check("time", 32'(dut_time()), 32'(x.t));
    end
    ticks_seen += int'(tick_1hz);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset, then dial in hh:mm through set mode and return to run mode
  task automatic preset(input int h, input int m);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < h; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < m; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    ticks_seen = 0;

    // Reset state
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_time", 32'(dut_time()), 32'h0);
    check("reset_tick", 32'(tick_1hz), 32'h0);

    // Eight running cycles: ticks on cycles 4 and 8
    tick_vec = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick_vec[i] = tick_1hz;
    end
    check("run8_ticks", 32'(tick_vec), 32'h88);
    check("run8_time", 32'(dut_time()), 32'h000002);

    // Full-day rollover
    preset(23, 59);
    run(58 * CLK_HZ);
    check("pre_2358", 32'(dut_time()), 32'h235958);
    run(CLK_HZ);
    check("at_235959", 32'(dut_time()), 32'h235959);
    run(CLK_HZ - 1);
    check("hold_235959", 32'(dut_time()), 32'h235959);
    run(1);
    check("rollover_time", 32'(dut_time()), 32'h000000);
    check("rollover_tick", 32'(tick_1hz), 32'h1);

    // 61 minute pulses in set mode
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ticks_seen = 0;
    for (int i = 0; i < 61; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    check("set61_time", 32'(dut_time()), 32'h000100);
    check("set61_ticks", 32'(ticks_seen), 32'd0);

    // Simultaneous minute and hour increment from 09:59
    preset(9, 59);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("both_inc", 32'(dut_time()), 32'h100000);

    // Seconds are cleared on entering set mode
    run(3 * CLK_HZ);
    check("run_3s", 32'(dut_time()), 32'h100003);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("set_clr_sec", 32'(dut_time()), 32'h100000);

    // Freeze at 12:34:56 with the prescaler part-way through a second
    preset(12, 34);
    run(56 * CLK_HZ);
    check("at_123456", 32'(dut_time()), 32'h123456);
    run(2);
    ticks_seen = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("frozen_time", 32'(dut_time()), 32'h123456);
    check("frozen_ticks", 32'(ticks_seen), 32'd0);
    tick_vec = '0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick_vec[i] = tick_1hz;
    end
    check("resume_ticks", 32'(tick_vec), 32'h2);
    check("resume_time", 32'(dut_time()), 32'h123457);

    // Reset on the rollover cycle, then hour pulses outside set mode
    preset(23, 59);
    run(59 * CLK_HZ + CLK_HZ - 1);
    check("pre_rst_time", 32'(dut_time()), 32'h235959);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("rst_roll_time", 32'(dut_time()), 32'h000000);
    check("rst_roll_tick", 32'(tick_1hz), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("inc_hr_ignored", 32'(dut_time()), 32'h000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_clock_time_counter
